// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared encodings and helpers for the execute stage
package exec_pkg;

  localparam logic [2:0] ALUK_ADD   = 3'b000;
  localparam logic [2:0] ALUK_AND   = 3'b001;
  localparam logic [2:0] ALUK_NOT   = 3'b010;
  localparam logic [2:0] ALUK_PASSA = 3'b011;
  localparam logic [2:0] ALUK_MUL   = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;

  localparam logic [2:0] NZP_RESET = 3'b010;

  // Sign-extends the low imm_w bits of imm to 64 bits; callers cast down to WIDTH.
  function automatic logic [63:0] sext(input logic [63:0] imm, input int imm_w);
    logic [63:0] hi_mask;
    logic        sign;
    hi_mask = ~64'd0 << imm_w;
    sign    = |(imm & (64'd1 << (imm_w - 1)));
    return (imm & ~hi_mask) | ({64{sign}} & hi_mask);
  endfunction

endpackage

// File: rtl/exec_if.sv
// rtl/exec_if.sv - issue, result, bus-load and debug signals of the execute stage
interface exec_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMM_W = 5
);
  localparam int AW = $clog2(NREGS);

  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_aluk;
  logic [AW-1:0]    i_dr;
  logic [AW-1:0]    i_sr1;
  logic [AW-1:0]    i_sr2;
  logic             i_imm_sel;
  logic [IMM_W-1:0] i_imm;
  logic             i_ld_reg;
  logic             i_bus_ld;
  logic [AW-1:0]    i_bus_dr;
  logic [WIDTH-1:0] i_bus;
  logic [WIDTH-1:0] o_result;
  logic             o_done;
  logic [2:0]       o_nzp;
  logic [AW-1:0]    i_dbg_addr;
  logic [WIDTH-1:0] o_dbg_data;

  modport master (
    output i_valid, i_aluk, i_dr, i_sr1, i_sr2, i_imm_sel, i_imm, i_ld_reg,
           i_bus_ld, i_bus_dr, i_bus, i_dbg_addr,
    input  o_ready, o_result, o_done, o_nzp, o_dbg_data
  );

  modport slave (
    input  i_valid, i_aluk, i_dr, i_sr1, i_sr2, i_imm_sel, i_imm, i_ld_reg,
           i_bus_ld, i_bus_dr, i_bus, i_dbg_addr,
    output o_ready, o_result, o_done, o_nzp, o_dbg_data
  );
endinterface

// File: rtl/exec_regfile.sv
// rtl/exec_regfile.sv - general registers, three async reads, two writes (port 0 wins)
module exec_regfile #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra0,
  output logic [WIDTH-1:0] rd0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd2,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1
);
  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      if (we1 && !(we0 && (wa0 == wa1))) mem[wa1] <= wd1;
      if (we0)                           mem[wa0] <= wd0;
    end
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - registered-operand execute stage with iterative multiply and NZP codes
module exec_unit
  import exec_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  parameter  int IMM_W = 5,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  exec_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [2:0]       aluk_q;
  logic [AW-1:0]    dr_q;
  logic             ld_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [2:0]       nzp_q;

  logic [WIDTH-1:0] rd_a, rd_b, b_imm, b_op, alu_res;
  logic [2:0]       nzp_new;
  logic             wb_en;

  assign b_imm = WIDTH'(sext({{(64-IMM_W){1'b0}}, bus.i_imm}, IMM_W));
  assign b_op  = bus.i_imm_sel ? b_imm : rd_b;
  assign wb_en = (state == ST_EXEC) && ld_q;

  always_comb begin
    alu_res = a_q;
    case (aluk_q)
      ALUK_ADD: alu_res = a_q + b_q;
      ALUK_AND: alu_res = a_q & b_q;
      ALUK_NOT: alu_res = ~a_q;
      ALUK_MUL: alu_res = acc_q;
      default:  alu_res = a_q;
    endcase
  end

  assign nzp_new = {alu_res[WIDTH-1], alu_res == '0,
                    !alu_res[WIDTH-1] && (alu_res != '0)};

  exec_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk   (i_CLK),
    .rst_n (i_RST_N),
    .ra0   (bus.i_sr1),
    .rd0   (rd_a),
    .ra1   (bus.i_sr2),
    .rd1   (rd_b),
    .ra2   (bus.i_dbg_addr),
    .rd2   (bus.o_dbg_data),
    .we0   (wb_en),
    .wa0   (dr_q),
    .wd0   (alu_res),
    .we1   (bus.i_bus_ld),
    .wa1   (bus.i_bus_dr),
    .wd1   (bus.i_bus)
  );

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      aluk_q   <= ALUK_ADD;
      dr_q     <= '0;
      ld_q     <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      nzp_q    <= NZP_RESET;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_valid) begin
            a_q    <= rd_a;
            b_q    <= b_op;
            aluk_q <= bus.i_aluk;
            dr_q   <= bus.i_dr;
            ld_q   <= bus.i_ld_reg;
            acc_q  <= '0;
            cnt_q  <= '0;
            state  <= (bus.i_aluk == ALUK_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_MUL: begin
          // Multiplicand shifts left while the multiplier drains LSB-first.
          acc_q <= acc_q + (b_q[0] ? a_q : '0);
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state <= ST_EXEC;
        end
        ST_EXEC: begin
          result_q <= alu_res;
          done_q   <= 1'b1;
          if (ld_q) nzp_q <= nzp_new;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready  = (state == ST_IDLE);
  assign bus.o_result = result_q;
  assign bus.o_done   = done_q;
  assign bus.o_nzp    = nzp_q;
endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed bench with a transaction-level model of the execute stage
module tb_exec_unit;
  localparam int W  = 16;
  localparam int NR = 8;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   run = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exec_if #(.WIDTH(W), .NREGS(NR), .IMM_W(IW)) ifc ();
  exec_unit #(.WIDTH(W), .NREGS(NR), .IMM_W(IW)) dut (
    .i_CLK   (clk),
    .i_RST_N (rst_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each accepted op is evaluated on the spot and its effects are scheduled
  // for the cycle the result must appear.
  logic [W-1:0] m_rf [NR];
  logic [W-1:0] m_result, p_res, ma, mb;
  logic [2:0]   m_nzp, p_dr;
  logic         m_done, m_busy, p_ld, m_busy_pre, m_wb;
  int           m_cyc, p_cyc;

  function automatic logic [W-1:0] model_op(input logic [2:0] k, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = a * b;
    case (k)
      3'd0:    return a + b;
      3'd1:    return a & b;
      3'd2:    return ~a;
      3'd4:    return prod[W-1:0];
      default: return a;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_rf[i] = '0;
      m_result = '0; m_nzp = 3'b010; m_done = 0; m_busy = 0; m_cyc = 0;
    end else begin
      m_cyc++;
      m_busy_pre = m_busy;
      m_done = 0;
      m_wb = 0;
      if (ifc.i_valid && !m_busy_pre) begin
        ma = m_rf[ifc.i_sr1];
        mb = ifc.i_imm_sel ? {{(W-IW){ifc.i_imm[IW-1]}}, ifc.i_imm} : m_rf[ifc.i_sr2];
        p_res = model_op(ifc.i_aluk, ma, mb);
        p_cyc = m_cyc + ((ifc.i_aluk == 3'd4) ? W + 1 : 1);
        p_dr = ifc.i_dr;
        p_ld = ifc.i_ld_reg;
        m_busy = 1;
      end
      if (m_busy_pre && m_cyc == p_cyc) begin
        m_result = p_res;
        m_done = 1;
        m_busy = 0;
        if (p_ld) begin
          m_rf[p_dr] = p_res;
          m_nzp = {p_res[W-1], p_res == '0, !p_res[W-1] && p_res != '0};
          m_wb = 1;
        end
      end
      if (ifc.i_bus_ld && !(m_wb && ifc.i_bus_dr == p_dr)) m_rf[ifc.i_bus_dr] = ifc.i_bus;
    end
  end

  always @(negedge clk) begin
    if (run && rst_n) begin
      chk("ready",  ifc.o_ready,    !m_busy);
      chk("done",   ifc.o_done,     m_done);
      chk("result", ifc.o_result,   m_result);
      chk("nzp",    ifc.o_nzp,      m_nzp);
      chk("dbg",    ifc.o_dbg_data, m_rf[ifc.i_dbg_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    ifc.i_dbg_addr = ifc.i_dbg_addr + 3'd1;
  endtask

  task automatic bus_load(input logic [2:0] r, input logic [W-1:0] d);
    ifc.i_bus_ld = 1; ifc.i_bus_dr = r; ifc.i_bus = d;
    tick();
    ifc.i_bus_ld = 0;
  endtask

  task automatic issue(input logic [2:0] k, input logic [2:0] dr, input logic [2:0] s1,
                       input logic [2:0] s2, input logic isel, input logic [IW-1:0] imm,
                       input logic ld);
    ifc.i_aluk = k; ifc.i_dr = dr; ifc.i_sr1 = s1; ifc.i_sr2 = s2;
    ifc.i_imm_sel = isel; ifc.i_imm = imm; ifc.i_ld_reg = ld; ifc.i_valid = 1;
    tick();
    ifc.i_valid = 0;
  endtask

  task automatic wait_done(input string name, input int lat, input logic [W-1:0] res,
                           input logic [2:0] nzp);
    int n = 0;
    while (!ifc.o_done && n < lat + 5) begin
      tick();
      n++;
    end
    if (!ifc.o_done) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_latency"}, n, lat);
      chk({name, "_result"}, ifc.o_result, res);
      chk({name, "_nzp"}, ifc.o_nzp, nzp);
    end
  endtask

  task automatic read_reg(input string name, input logic [2:0] r, input logic [W-1:0] exp);
    ifc.i_dbg_addr = r;
    #1;
    chk(name, ifc.o_dbg_data, exp);
  endtask

  initial begin
    ifc.i_valid = 0; ifc.i_aluk = 0; ifc.i_dr = 0; ifc.i_sr1 = 0; ifc.i_sr2 = 0;
    ifc.i_imm_sel = 0; ifc.i_imm = 0; ifc.i_ld_reg = 0; ifc.i_bus_ld = 0;
    ifc.i_bus_dr = 0; ifc.i_bus = 0; ifc.i_dbg_addr = 0;
    tick(); tick();
    chk("rst_ready", ifc.o_ready, 1);
    chk("rst_done", ifc.o_done, 0);
    chk("rst_nzp", ifc.o_nzp, 3'b010);
    chk("rst_result", ifc.o_result, 0);
    read_reg("rst_r1", 1, 0);
    rst_n = 1;
    run = 1;

    bus_load(1, 3);
    bus_load(2, 4);
    issue(3'd0, 3, 1, 2, 0, 0, 1);
    wait_done("add", 1, 7, 3'b001);
    read_reg("add_r3", 3, 7);

    issue(3'd0, 1, 1, 0, 1, 5'd8, 1);
    wait_done("addi_self", 1, 11, 3'b001);
    repeat (5) tick();
    read_reg("addi_r1", 1, 11);

    issue(3'd2, 4, 0, 0, 0, 0, 1);
    wait_done("not", 1, 16'hFFFF, 3'b100);
    read_reg("not_r4", 4, 16'hFFFF);
    issue(3'd1, 4, 1, 0, 1, 5'd0, 1);
    wait_done("andi0", 1, 0, 3'b010);
    read_reg("and_r4", 4, 0);

    bus_load(1, 300);
    bus_load(2, 300);
    issue(3'd4, 5, 1, 2, 0, 0, 1);
    ifc.i_aluk = 3'd0; ifc.i_dr = 7; ifc.i_sr1 = 1; ifc.i_imm_sel = 1;
    ifc.i_imm = 5'd1; ifc.i_ld_reg = 1; ifc.i_valid = 1;
    repeat (5) tick();
    ifc.i_valid = 0;
    wait_done("mul", W + 1 - 5, 16'd24464, 3'b001);
    read_reg("mul_r5", 5, 16'd24464);
    read_reg("mul_ignored_r7", 7, 0);

    issue(3'd0, 0, 2, 0, 1, 5'b11011, 0);
    wait_done("addneg_nold", 1, 16'd295, 3'b001);
    read_reg("nold_r0", 0, 0);

    issue(3'd0, 6, 1, 0, 1, 5'd1, 1);
    ifc.i_bus_ld = 1; ifc.i_bus_dr = 6; ifc.i_bus = 16'hAAAA;
    tick();
    ifc.i_bus_ld = 0;
    wait_done("collide", 0, 16'd301, 3'b001);
    read_reg("collide_r6", 6, 16'd301);

    issue(3'd3, 6, 2, 0, 0, 0, 1);
    ifc.i_bus_ld = 1; ifc.i_bus_dr = 7; ifc.i_bus = 16'h1234;
    tick();
    ifc.i_bus_ld = 0;
    wait_done("passa", 0, 16'd300, 3'b001);
    read_reg("passa_r6", 6, 16'd300);
    read_reg("bus_r7", 7, 16'h1234);

    issue(3'd4, 5, 1, 2, 0, 0, 1);
    repeat (5) tick();
    rst_n = 0;
    #1;
    chk("abort_ready", ifc.o_ready, 1);
    chk("abort_done", ifc.o_done, 0);
    chk("abort_nzp", ifc.o_nzp, 3'b010);
    for (int r = 0; r < NR; r++) read_reg("abort_reg", 3'(r), 0);
    tick();
    rst_n = 1;
    repeat (20) tick();
    issue(3'd0, 1, 0, 0, 1, 5'd5, 1);
    wait_done("post_rst", 1, 16'd5, 3'b001);

    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised execute stage for the LC-3 datapath. It replaces the combinational register-file/ALU pair with a registered operand-capture design, which removes the RX <- RX + imm write-back feedback loop. It adds a valid/ready issue handshake, an iterative multiply, and NZP condition codes. It sits between the control FSM (issue side) and the bus gate (result side), and keeps its own bus write port for loads.

## Interface
Parameters:
- WIDTH, 16, datapath width in bits (>= 8)
- NREGS, 8, number of general registers (power of two)
- AW, $clog2(NREGS), register address width (derived, not overridden)
- IMM_W, 5, immediate field width (< WIDTH)

Ports:
- i_CLK  in  1  system clock. One clock domain only; all state changes on its rising edge.
- i_RST_N  in  1  asynchronous, active-low reset
- i_valid  in  1  issue request
- o_ready  out  1  high in IDLE only; issue accepted on a rising edge where i_valid & o_ready
- i_aluk  in  3  000 ADD, 001 AND, 010 NOT, 011 PASSA, 100 MUL, others = PASSA
- i_dr  in  AW  destination register
- i_sr1  in  AW  source A
- i_sr2  in  AW  source B (register mode)
- i_imm_sel  in  1  1: B = sign-extended i_imm
- i_imm  in  IMM_W  immediate
- i_ld_reg  in  1  write result to rf[i_dr] and update NZP
- i_bus_ld  in  1  load i_bus into rf[i_bus_dr]
- i_bus_dr  in  AW  bus load destination
- i_bus  in  WIDTH  bus data
- o_result  out  WIDTH  last result, registered (to bus gate)
- o_done  out  1  one-cycle pulse; o_result/o_nzp are new
- o_nzp  out  3  {N,Z,P} of the last written result
- i_dbg_addr  in  AW  debug read address
- o_dbg_data  out  WIDTH  combinational rf[i_dbg_addr]

## Operation
- States: IDLE, MUL, EXEC.
- IDLE:
  - On accept: capture A = rf[i_sr1] and B = imm_sel ? sext(i_imm) : rf[i_sr2], plus aluk, dr and ld_reg.
  - Capture uses values from before the edge; there is no bypass.
  - MUL goes to MUL with cnt=0, acc=0. Any other op goes to EXEC.
- MUL: shift-add, one bit of B per cycle, LSB first. Runs WIDTH cycles, then goes to EXEC. Result is the low WIDTH bits of A*B.
- EXEC: compute the ADD/AND/NOT(A)/PASSA result, or take the MUL accumulator. On the leaving edge:
  - o_result <= result
  - o_done <= 1
  - if ld_reg: write rf[dr] and set nzp (N = MSB, Z = all zero, P otherwise)
  - go to IDLE
- Arithmetic is modulo 2^WIDTH. Overflow is not flagged.
- Bus load: writes at any edge, in any state.
  - If it hits the same register as an EXEC write-back on the same edge, the EXEC write wins.
  - Otherwise both writes occur.
  - A bus load never touches NZP.
- i_valid while o_ready=0 is ignored. The issuer holds the request until it is accepted.
- Reset (async):
  - rf all 0, o_result 0, o_done 0, o_nzp 3'b010, state IDLE (o_ready 1).
  - An operation in flight is aborted with no write.

## Timing
- Single-cycle ops: accept at edge T; o_done high in the cycle after edge T+1.
- MUL: o_done after edge T+WIDTH+1.
- o_ready returns high in the same cycle o_done is high. Back-to-back issue gives one result every 2 cycles.
- A written register is readable as an operand on the first accept after write-back. Because capture is registered, a self-referencing op (R1 <- R1 + 8) writes exactly once.
- o_dbg_data reflects a write in the cycle after the write edge.

## Structure
- Package exec_pkg holds:
  - ALUK encodings
  - state enum
  - NZP reset constant 3'b010
  - sext function
- Sub-module exec_regfile(WIDTH, NREGS):
  - three asynchronous read ports (sr1, sr2, dbg)
  - two write ports; port 0 (EXEC) has priority over port 1 (bus) on an address match
  - asynchronous active-low reset

## Test plan
- Reset then bus-load R1=3, R2=4; issue ADD R3<-R1+R2 -> o_done after 2 edges, o_result=7, R3=7, nzp=001.
- ADD R1<-R1+imm 8 (R1=3) -> R1=11 exactly, one write, no further change over 5 idle cycles.
- NOT R4<-R0 (R0=0) -> 16'hFFFF, nzp=100. AND with imm 0 -> 0, nzp=010.
- MUL R5<-R1*R2 (R1=300, R2=300) -> o_ready low for WIDTH+1 cycles, result 90000 mod 65536 = 24464. i_valid during MUL is ignored.
- Same-edge EXEC write-back to R6 and bus load of R6=16'hAAAA -> R6 holds the EXEC result. A bus load to R7 on the same edge succeeds.
- Assert i_RST_N low mid-MUL -> immediate abort; all registers 0, nzp=010, o_ready=1, no o_done.
